// File: rtl/hex_scroll_ctrl_pkg.sv
// hex_scroll_ctrl_pkg: shared FSM state, character codes and active-low segment constants
package hex_scroll_ctrl_pkg;
  typedef enum logic {ST_IDLE, ST_SCROLL} state_t;
  localparam logic [4:0] CH_BLANK = 5'd16;
  localparam logic [4:0] CH_DASH = 5'd17;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: i_code (0-15 hex, 17 dash, else blank) to o_seg active-low segments, bit0=a..bit6=g
module seg7_decode
  import hex_scroll_ctrl_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);
  always_comb o_seg = i_code < 5'd16 ? SEG_HEX[i_code[3:0]] : i_code == CH_DASH ? SEG_DASH : SEG_BLANK;
endmodule

// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: buffered character scroller over six digits; ports clk/reset, wr_valid/wr_ready/wr_char, cmd_start/stop/clear, pause, hex0..hex5 (active-low), busy, count
module hex_scroll_ctrl
  import hex_scroll_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 12500000,
  parameter int BUF_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_char,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_clear,
  input  logic       pause,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       busy,
  output logic [4:0] count
);
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam logic [23:0] PRE_MAX = 24'(STEP_DIV - 1);
  state_t r_state, w_state_nxt;
  logic [4:0] r_buf [BUF_DEPTH];
  logic [4:0] r_count;
  logic [5:0] r_pos;
  logic [23:0] r_pre;
  logic [6:0] r_hex [6];
  logic [4:0] w_code [6];
  logic [6:0] w_seg [6];
  logic [4:0] w_count_wr;
  logic [5:0] w_n;
  logic w_wr, w_step;
  assign wr_ready = r_state == ST_IDLE && r_count < 5'(BUF_DEPTH);
  assign w_wr = wr_valid && wr_ready;
  assign w_count_wr = r_count + {4'd0, w_wr};
  assign w_n = {1'b0, r_count} + 6'd6;
  assign w_step = r_state == ST_SCROLL && !cmd_stop && !pause && r_pre == PRE_MAX;
  always_comb begin
    w_state_nxt = r_state == ST_IDLE ? ((cmd_start && !cmd_clear && w_count_wr != 5'd0) ? ST_SCROLL : ST_IDLE)
                                     : (cmd_stop ? ST_IDLE : ST_SCROLL);
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_count[AW-1:0]] <= wr_char;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 5'd0;
      r_pos <= 6'd0;
      r_pre <= 24'd0;
    end else if (r_state == ST_IDLE) begin
      r_count <= cmd_clear ? 5'd0 : w_count_wr;
      r_pos <= 6'd0;
      r_pre <= 24'd0;
    end else if (!cmd_stop && !pause) begin
      r_pre <= w_step ? 24'd0 : r_pre + 24'd1;
      if (w_step) r_pos <= r_pos == w_n - 6'd1 ? 6'd0 : r_pos + 6'd1;
    end
  end
  for (genvar j = 0; j < 6; j++) begin : g_dig
    logic [5:0] w_raw, w_idx;
    assign w_raw = r_pos + 6'(5 - j);
    assign w_idx = w_raw >= w_n ? w_raw - w_n : w_raw;
    assign w_code[j] = (r_state == ST_SCROLL && w_idx >= 6'd6) ? r_buf[AW'(w_idx - 6'd6)] : CH_BLANK;
    seg7_decode u_dec (.i_code(w_code[j]), .o_seg(w_seg[j]));
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < 6; j++) r_hex[j] <= reset ? SEG_BLANK : w_seg[j];
  end
  assign {hex5, hex4, hex3, hex2, hex1, hex0} = {r_hex[5], r_hex[4], r_hex[3], r_hex[2], r_hex[1], r_hex[0]};
  assign busy = r_state == ST_SCROLL;
  assign count = r_count;
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// tb_hex_scroll_ctrl: directed self-checking bench for hex_scroll_ctrl at STEP_DIV=4
module tb_hex_scroll_ctrl;
  logic clk = 1'b0;
  logic reset, wr_valid, wr_ready, cmd_start, cmd_stop, cmd_clear, pause, busy;
  logic [4:0] wr_char, count;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] hex_all;
  localparam logic [41:0] BLANK6 = {6{7'h7F}};
  int errors = 0, checks = 0;
  logic [4:0] mbuf [32];
  int mcount = 0, m_act = 0;
  always #5 clk = ~clk;
  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};
  hex_scroll_ctrl #(.STEP_DIV(4), .BUF_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .pause(pause),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy), .count(count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] seg_of(input logic [4:0] c);
    case (c)
      5'd0: return 7'h40;   5'd1: return 7'h79;   5'd2: return 7'h24;   5'd3: return 7'h30;
      5'd4: return 7'h19;   5'd5: return 7'h12;   5'd6: return 7'h02;   5'd7: return 7'h78;
      5'd8: return 7'h00;   5'd9: return 7'h10;   5'd10: return 7'h08;  5'd11: return 7'h03;
      5'd12: return 7'h46;  5'd13: return 7'h21;  5'd14: return 7'h06;  5'd15: return 7'h0E;
      5'd17: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction
  function automatic logic [41:0] exp_hex(input int p, input int n);
    logic [41:0] r;
    r = '0;
    for (int j = 0; j < 6; j++) begin
      int idx;
      idx = (p + 5 - j) % n;
      r[j*7 +: 7] = seg_of(idx < 6 ? 5'd16 : mbuf[idx-6]);
    end
    return r;
  endfunction
  task automatic wr(input logic [4:0] c);
    wr_valid = 1'b1;
    wr_char = c;
    tick();
    wr_valid = 1'b0;
    mbuf[mcount] = c;
    mcount++;
  endtask
  task automatic start;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    m_act = 0;
  endtask
  task automatic run(input int cyc, input logic pz, input string tag);
    for (int i = 0; i < cyc; i++) begin
      int p;
      p = (m_act / 4) % (mcount + 6);
      pause = pz;
      tick();
      if (!pz) m_act++;
      chk(tag, hex_all, exp_hex(p, mcount + 6));
      chk({tag, "_rdy"}, wr_ready, 0);
    end
    pause = 1'b0;
  endtask
  task automatic stop;
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
  endtask
  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_char = 5'd0; cmd_start = 1'b0;
    cmd_stop = 1'b0; cmd_clear = 1'b0; pause = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_hex", hex_all, BLANK6);
    start();
    chk("start_empty", busy, 0);
    wr(5'd1); wr(5'd2); wr(5'd3);
    chk("count3", count, 3);
    start();
    chk("start_busy", busy, 1);
    chk("start_count", count, 3);
    chk("start_ready", wr_ready, 0);
    wr_valid = 1'b1;
    wr_char = 5'd9;
    run(5, 1'b0, "scr");
    chk("pos1_hex0", hex0, 7'h79);
    chk("pos1_rest", hex_all[41:7], {5{7'h7F}});
    run(8, 1'b0, "scr");
    chk("pos3_hex2", hex2, 7'h79);
    chk("pos3_hex1", hex1, 7'h24);
    chk("pos3_hex0", hex0, 7'h30);
    run(27, 1'b0, "scr");
    wr_valid = 1'b0;
    chk("wrap_blank", hex_all, BLANK6);
    chk("scroll_drop", count, 3);
    run(2, 1'b0, "pre");
    run(10, 1'b1, "pause");
    run(12, 1'b0, "resume");
    stop();
    chk("stop_busy", busy, 0);
    chk("stop_count", count, 3);
    tick();
    chk("stop_hex", hex_all, BLANK6);
    start();
    chk("restart_busy", busy, 1);
    run(6, 1'b0, "restart");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mcount = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_hex", hex_all, BLANK6);
    wr(5'd4); wr(5'd5);
    cmd_clear = 1'b1;
    start();
    cmd_clear = 1'b0;
    mcount = 0;
    chk("clr_start_count", count, 0);
    chk("clr_start_busy", busy, 0);
    wr_valid = 1'b1;
    wr_char = 5'd5;
    start();
    wr_valid = 1'b0;
    mbuf[0] = 5'd5;
    mcount = 1;
    chk("wr_start_busy", busy, 1);
    chk("wr_start_count", count, 1);
    run(5, 1'b0, "one");
    chk("one_hex0", hex0, 7'h12);
    run(25, 1'b0, "one");
    stop();
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    mcount = 0;
    chk("clear_count", count, 0);
    for (int i = 0; i < 16; i++) begin
      chk("fill_ready", wr_ready, 1);
      wr(i == 14 ? 5'd17 : i == 15 ? 5'd20 : 5'(i));
    end
    chk("full_ready", wr_ready, 0);
    chk("full_count", count, 16);
    wr_valid = 1'b1;
    wr_char = 5'd7;
    tick();
    wr_valid = 1'b0;
    chk("full_drop", count, 16);
    start();
    chk("full_busy", busy, 1);
    run(22 * 4 + 4, 1'b0, "full");
    stop();
    chk("full_stop_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
